// File: rtl/aes_busb_round_ctrl.sv
// Round sequencer for the AES-128/192/256 encryption datapath: steers bus B and
// raises the per-phase enables for each SubBytes / MixColumns / AddRoundKey step.
module aes_busb_round_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       key_rdy,
    output logic [1:0] SEL_busB,
    output logic       ld_en,
    output logic       sub_en,
    output logic       mix_en,
    output logic       ark_en,
    output logic [3:0] key_rnd,
    output logic       busy,
    output logic       done
);

    generate
        if ((NR != 10) && (NR != 12) && (NR != 14)) begin : g_bad_nr
            $error("aes_busb_round_ctrl: NR must be 10, 12 or 14");
        end
    endgenerate

    localparam logic [3:0] LastMidRnd = 4'(NR - 1);

    localparam logic [1:0] SelState  = 2'b00;
    localparam logic [1:0] SelKey    = 2'b01;
    localparam logic [1:0] SelMix    = 2'b10;
    localparam logic [1:0] SelConfig = 2'b11;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StInitArk,
        StRSub,
        StRMix,
        StRArk,
        StFSub,
        StFArk,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = StInitArk;
                cnt_d   = 4'd0;
            end
            StInitArk: begin
                if (key_rdy) begin
                    state_d = StRSub;
                    cnt_d   = 4'd1;
                end
            end
            StRSub: state_d = StRMix;
            StRMix: state_d = StRArk;
            StRArk: begin
                if (key_rdy) begin
                    state_d = (cnt_q == LastMidRnd) ? StFSub : StRSub;
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            StFSub: state_d = StFArk;
            StFArk: begin
                if (key_rdy) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase

        // DONE always completes so its pulse cannot be swallowed by a late abort.
        if (abort && (state_q != StIdle) && (state_q != StDone)) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
        end
    end

    always_comb begin
        SEL_busB = SelState;
        ld_en    = 1'b0;
        sub_en   = 1'b0;
        mix_en   = 1'b0;
        ark_en   = 1'b0;
        done     = 1'b0;
        busy     = (state_q != StIdle) && (state_q != StDone);
        key_rnd  = cnt_q;
        unique case (state_q)
            StIdle: ;
            StLoad: begin
                SEL_busB = SelConfig;
                ld_en    = 1'b1;
            end
            // ark_en is qualified by key_rdy so a stale round key is never added.
            StInitArk, StRArk, StFArk: begin
                SEL_busB = SelKey;
                ark_en   = key_rdy;
            end
            StRSub, StFSub: sub_en = 1'b1;
            StRMix: begin
                SEL_busB = SelMix;
                mix_en   = 1'b1;
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_busb_round_ctrl.sv
// Directed bench for aes_busb_round_ctrl. Cycle 1 of a block is the LOAD cycle
// that follows the edge on which start is sampled.
module tb_aes_busb_round_ctrl;

    logic clk = 1'b0;
    logic rst, start, abort, key_rdy;

    logic [1:0] sel10, sel14;
    logic       ld10, sub10, mix10, ark10, busy10, done10;
    logic       ld14, sub14, mix14, ark14, busy14, done14;
    logic [3:0] krnd10, krnd14;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    aes_busb_round_ctrl #(.NR(10)) dut10 (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .key_rdy  (key_rdy),
        .SEL_busB (sel10),
        .ld_en    (ld10),
        .sub_en   (sub10),
        .mix_en   (mix10),
        .ark_en   (ark10),
        .key_rnd  (krnd10),
        .busy     (busy10),
        .done     (done10)
    );

    aes_busb_round_ctrl #(.NR(14)) dut14 (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .key_rdy  (key_rdy),
        .SEL_busB (sel14),
        .ld_en    (ld14),
        .sub_en   (sub14),
        .mix_en   (mix14),
        .ark_en   (ark14),
        .key_rnd  (krnd14),
        .busy     (busy14),
        .done     (done14)
    );

    logic [11:0] outs10, outs14;
    assign outs10 = {sel10, ld10, sub10, mix10, ark10, krnd10, busy10, done10};
    assign outs14 = {sel14, ld14, sub14, mix14, ark14, krnd14, busy14, done14};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] seq [32];
        int         cyc;
        int         ndone;
        logic       seen;

        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        key_rdy = 1'b1;
        #3;
        check("reset_outs10", 32'(outs10), 32'd0);
        check("reset_outs14", 32'(outs14), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        step();
        check("idle_outs10", 32'(outs10), 32'd0);

        // T1: full NR=10 block, bus-B select sequence and done timing
        seq[0] = 2'b11;
        seq[1] = 2'b01;
        for (int k = 0; k < 9; k++) begin
            seq[2 + 3 * k] = 2'b00;
            seq[3 + 3 * k] = 2'b10;
            seq[4 + 3 * k] = 2'b01;
        end
        seq[29] = 2'b00;
        seq[30] = 2'b01;
        seq[31] = 2'b00;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check($sformatf("t1_sel_c%0d", i + 1), 32'(sel10), 32'(seq[i]));
            check($sformatf("t1_done_c%0d", i + 1), 32'(done10), (i == 31) ? 32'd1 : 32'd0);
            if (i == 0) check("t1_ld_en", 32'(ld10), 32'd1);
            if (i == 1) check("t1_init_krnd", 32'(krnd10), 32'd0);
            if (i == 30) check("t1_fark_krnd", 32'(krnd10), 32'd10);
            step();
        end
        check("t1_after_busy", 32'(busy10), 32'd0);
        check("t1_after_krnd", 32'(krnd10), 32'd0);
        repeat (14) step();

        // T2: NR=14 latency and final round index
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 43) begin
                check("t2_fark_krnd", 32'(krnd14), 32'd14);
                check("t2_fark_sel", 32'(sel14), 32'd1);
            end
            if (done14) begin
                cyc = c;
                break;
            end
            step();
        end
        check("t2_done_cycle", 32'(cyc), 32'd44);
        step();

        // T3: three-cycle key stall in round-5 R_ARK
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 60; c++) begin
            key_rdy = !((c >= 17) && (c <= 19));
            #1;
            if ((c >= 17) && (c <= 19)) begin
                check($sformatf("t3_stall_sel_c%0d", c), 32'(sel10), 32'd1);
                check($sformatf("t3_stall_ark_c%0d", c), 32'(ark10), 32'd0);
                check($sformatf("t3_stall_krnd_c%0d", c), 32'(krnd10), 32'd5);
            end
            if (c == 20) check("t3_resume_ark", 32'(ark10), 32'd1);
            if (done10) begin
                cyc = c;
                break;
            end
            step();
        end
        key_rdy = 1'b1;
        check("t3_done_cycle", 32'(cyc), 32'd35);
        step();

        // T4: abort in round-3 R_MIX, then a clean block
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        check("t4_rmix_sel", 32'(sel10), 32'd2);
        check("t4_rmix_krnd", 32'(krnd10), 32'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_abort_outs", 32'(outs10), 32'd0);
        seen = 1'b0;
        repeat (5) begin
            if (done10) seen = 1'b1;
            step();
        end
        check("t4_no_done", 32'(seen), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 60; c++) begin
            if (done10) begin
                cyc = c;
                break;
            end
            step();
        end
        check("t4_rerun_cycle", 32'(cyc), 32'd32);
        step();

        // T5: start pulses in R_SUB and in DONE are ignored
        start = 1'b1;
        step();
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 3) check("t5_rsub_en", 32'(sub10), 32'd1);
            if (c == 32) check("t5_done_pulse", 32'(done10), 32'd1);
            if ((c == 33) || (c == 34)) begin
                check($sformatf("t5_idle_busy_c%0d", c), 32'(busy10), 32'd0);
                check($sformatf("t5_idle_ld_c%0d", c), 32'(ld10), 32'd0);
            end
            if (done10) ndone++;
            start = (c == 3) || (c == 32);
            step();
            start = 1'b0;
        end
        check("t5_done_count", 32'(ndone), 32'd1);

        // T6: asynchronous reset during F_SUB
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (29) step();
        check("t6_fsub_en", 32'(sub10), 32'd1);
        check("t6_fsub_krnd", 32'(krnd10), 32'd10);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_outs", 32'(outs10), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            if (done10) seen = 1'b1;
            step();
        end
        check("t6_no_done", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
